// File: rtl/fti_pkg.sv
// Shared definitions for the float-to-integer colour converter: IEEE-754
// single-precision field layout, bias, channel count and value classes.
package fti_pkg;

    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int FLOAT_W  = SIGN_W + EXP_W + MANT_W;
    localparam int EXP_BIAS = 127;
    localparam int NUM_CH   = 3;

    typedef enum logic [2:0] {
        FT_ZERO,
        FT_NORM,
        FT_NEG,
        FT_NAN,
        FT_INF
    } fti_class_e;

endpackage

// File: rtl/fti_channel.sv
// One channel of the float-to-integer datapath: S1 unpack/classify, S2
// shift/round/saturate. SAT_FLAG support is built only with FTI_SAT_FLAG_EN.
module fti_channel
    import fti_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en1,
    input  logic               en2,
    input  logic [FLOAT_W-1:0] din,
    output logic [OUT_W-1:0]   dout
`ifdef FTI_SAT_FLAG_EN
    ,
    output logic               sat
`endif
);

    localparam logic [25:0]      MAX_VAL = 26'((1 << OUT_W) - 1);
    localparam logic [OUT_W-1:0] OUT_MAX = '1;

    logic              sign;
    logic [EXP_W-1:0]  exp_f;
    logic [MANT_W-1:0] mant_f;
    fti_class_e        cls_d;
    logic signed [9:0] e_d;

    fti_class_e        s1_cls;
    logic signed [9:0] s1_e;
    logic [MANT_W-1:0] s1_mant;

    assign {sign, exp_f, mant_f} = din;
    assign e_d = $signed({2'b00, exp_f}) - $signed(10'(EXP_BIAS));

    // -0 is treated as plain zero so it is not reported as clamped.
    always_comb begin
        if (exp_f == '1 && mant_f != '0)
            cls_d = FT_NAN;
        else if (sign)
            cls_d = ({exp_f, mant_f} == '0) ? FT_ZERO : FT_NEG;
        else if (exp_f == '1)
            cls_d = FT_INF;
        else if (exp_f == '0)
            cls_d = FT_ZERO;
        else
            cls_d = FT_NORM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_cls  <= FT_ZERO;
            s1_e    <= '0;
            s1_mant <= '0;
        end else if (en1) begin
            s1_cls  <= cls_d;
            s1_e    <= e_d;
            s1_mant <= mant_f;
        end
    end

    logic signed [9:0] shamt;
    logic [24:0]       shifted;
    logic [25:0]       rounded;
    logic              in_range;
    logic              upper_sat;
    logic [OUT_W-1:0]  dout_d;

    // Keeping one extra fraction bit below the integer lets half-up rounding
    // be a single add-one-then-halve; e = -1 falls out as 0.5..1 -> 1.
    assign shamt     = $signed(10'(MANT_W)) - s1_e;
    assign shifted   = {1'b1, s1_mant, 1'b0} >> $unsigned(shamt);
    assign rounded   = ({1'b0, shifted} + 26'd1) >> 1;
    assign in_range  = (s1_e >= -10'sd1) && (s1_e < $signed(10'(OUT_W)));
    assign upper_sat = (s1_cls == FT_NORM) &&
                       ((s1_e >= $signed(10'(OUT_W))) || (in_range && (rounded > MAX_VAL)));

    always_comb begin
        dout_d = '0;
        if (s1_cls == FT_INF || upper_sat)
            dout_d = OUT_MAX;
        else if (s1_cls == FT_NORM && in_range)
            dout_d = rounded[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dout <= '0;
        else if (en2)
            dout <= dout_d;
    end

`ifdef FTI_SAT_FLAG_EN
    logic sat_d;

    assign sat_d = (s1_cls == FT_NAN) || (s1_cls == FT_INF) || (s1_cls == FT_NEG) || upper_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat <= 1'b0;
        else if (en2)
            sat <= sat_d;
    end
`endif

endmodule

// File: rtl/converter_fti_block.sv
// RGB float-to-unsigned-integer converter, 2-stage valid/ready pipeline.
// Define FTI_SAT_FLAG_EN to add the per-channel SAT_FLAG output.
module converter_fti_block
    import fti_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic               CLK,
    input  logic               CLEAR,
    input  logic [FLOAT_W-1:0] Red_In,
    input  logic [FLOAT_W-1:0] Green_In,
    input  logic [FLOAT_W-1:0] Blue_In,
    input  logic               ENABLE_IN,
    output logic               READY_IN,
    output logic [OUT_W-1:0]   Red_Out,
    output logic [OUT_W-1:0]   Green_Out,
    output logic [OUT_W-1:0]   Blue_Out,
    output logic               ENABLE_OUT,
    input  logic               READY_OUT
`ifdef FTI_SAT_FLAG_EN
    ,
    output logic [NUM_CH-1:0]  SAT_FLAG
`endif
);

    logic v1, v2;
    logic adv1, adv2;
    logic load1, load2;

    assign adv2       = !v2 || READY_OUT;
    assign adv1       = !v1 || adv2;
    assign READY_IN   = adv1;
    assign ENABLE_OUT = v2;

    // Data registers only capture real transfers; bubbles leave them untouched.
    assign load1 = adv1 && ENABLE_IN;
    assign load2 = adv2 && v1;

    always_ff @(posedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (adv1) v1 <= ENABLE_IN;
            if (adv2) v2 <= v1;
        end
    end

    logic [FLOAT_W-1:0] ch_in  [NUM_CH];
    logic [OUT_W-1:0]   ch_out [NUM_CH];

    assign ch_in[0]  = Red_In;
    assign ch_in[1]  = Green_In;
    assign ch_in[2]  = Blue_In;
    assign Red_Out   = ch_out[0];
    assign Green_Out = ch_out[1];
    assign Blue_Out  = ch_out[2];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fti_channel #(
            .OUT_W (OUT_W)
        ) u_ch (
            .clk   (CLK),
            .rst_n (CLEAR),
            .en1   (load1),
            .en2   (load2),
            .din   (ch_in[i]),
            .dout  (ch_out[i])
`ifdef FTI_SAT_FLAG_EN
            ,
            .sat   (SAT_FLAG[NUM_CH-1-i])
`endif
        );
    end

endmodule

// File: tb/tb_converter_fti_block.sv
// Scoreboard bench for converter_fti_block at OUT_W=8 and OUT_W=12 side by
// side; the reference model converts floats with real arithmetic.
module tb_converter_fti_block;

    logic        CLK = 1'b0;
    logic        CLEAR = 1'b0;
    logic [31:0] Red_In = '0, Green_In = '0, Blue_In = '0;
    logic        ENABLE_IN = 1'b0;
    logic        READY_OUT = 1'b0;
    logic        READY_IN, READY_IN12;
    logic [7:0]  Red_Out, Green_Out, Blue_Out;
    logic [11:0] Red_Out12, Green_Out12, Blue_Out12;
    logic        ENABLE_OUT, ENABLE_OUT12;
`ifdef FTI_SAT_FLAG_EN
    logic [2:0]  SAT_FLAG, SAT_FLAG12;
`endif

    converter_fti_block #(.OUT_W(8)) dut8 (
        .CLK(CLK), .CLEAR(CLEAR),
        .Red_In(Red_In), .Green_In(Green_In), .Blue_In(Blue_In),
        .ENABLE_IN(ENABLE_IN), .READY_IN(READY_IN),
        .Red_Out(Red_Out), .Green_Out(Green_Out), .Blue_Out(Blue_Out),
        .ENABLE_OUT(ENABLE_OUT), .READY_OUT(READY_OUT)
`ifdef FTI_SAT_FLAG_EN
        , .SAT_FLAG(SAT_FLAG)
`endif
    );

    converter_fti_block #(.OUT_W(12)) dut12 (
        .CLK(CLK), .CLEAR(CLEAR),
        .Red_In(Red_In), .Green_In(Green_In), .Blue_In(Blue_In),
        .ENABLE_IN(ENABLE_IN), .READY_IN(READY_IN12),
        .Red_Out(Red_Out12), .Green_Out(Green_Out12), .Blue_Out(Blue_Out12),
        .ENABLE_OUT(ENABLE_OUT12), .READY_OUT(READY_OUT)
`ifdef FTI_SAT_FLAG_EN
        , .SAT_FLAG(SAT_FLAG12)
`endif
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int r8, g8, b8, s8;
        int r12, g12, b12, s12;
        int acc;
        bit lat;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Rounded value = floor(x + 0.5) of the real number, clamped to 0..2^w-1.
    function automatic void model(input logic [31:0] f, input int w, output int res, output bit sat);
        int  ex   = int'(f[30:23]);
        int  mant = int'(f[22:0]);
        int  maxv = (1 << w) - 1;
        real v;
        res = 0;
        sat = 1'b0;
        if (ex == 255 && mant != 0) begin
            sat = 1'b1;
        end else if (f[31]) begin
            sat = (f[30:0] != '0);
        end else if (ex == 255) begin
            res = maxv;
            sat = 1'b1;
        end else if (ex != 0) begin
            v = real'(mant + (1 << 23));
            for (int k = ex; k < 150; k++) v = v / 2.0;
            for (int k = 150; k < ex; k++) v = v * 2.0;
            v = v + 0.5;
            if (v >= real'(maxv + 1)) begin
                res = maxv;
                sat = 1'b1;
            end else begin
                res = $rtoi(v);
            end
        end
    endfunction

    function automatic void push(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b,
                                 input bit lat);
        exp_t e;
        bit   sr, sg, sb;
        model(r, 8, e.r8, sr);
        model(g, 8, e.g8, sg);
        model(b, 8, e.b8, sb);
        e.s8 = {29'd0, sr, sg, sb};
        model(r, 12, e.r12, sr);
        model(g, 12, e.g12, sg);
        model(b, 12, e.b12, sb);
        e.s12 = {29'd0, sr, sg, sb};
        e.acc = cyc + 1;
        e.lat = lat;
        q.push_back(e);
    endfunction

    // One cycle of stimulus, driven on the falling edge; accepted means the
    // following rising edge transfers the triplet.
    task automatic drive(input bit en, input logic [31:0] r, input logic [31:0] g,
                         input logic [31:0] b, input bit ro, input bit lat, output bit acc);
        @(negedge CLK);
        ENABLE_IN = en;
        Red_In    = r;
        Green_In  = g;
        Blue_In   = b;
        READY_OUT = ro;
        #1;
        acc = en && READY_IN;
        if (acc) push(r, g, b, lat);
    endtask

    task automatic send(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b,
                        input bit ro, input bit lat);
        bit a = 1'b0;
        int n = 0;
        while (!a && n < 50) begin
            drive(1'b1, r, g, b, ro, lat, a);
            n++;
        end
        if (!a) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n, input bit ro);
        bit a;
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, ro, 1'b0, a);
    endtask

    function automatic logic [31:0] rnd_float();
        int          k = $urandom_range(0, 9);
        logic [31:0] f = $urandom();
        logic [31:0] sp [6] = '{32'h7F800000, 32'h7FC00000, 32'h80000000,
                                32'h00000001, 32'hFF800000, 32'h3F000000};
        case (k)
            0, 1:    f = $urandom();
            2, 3, 4: f = {1'b0, 8'($urandom_range(120, 136)), 23'($urandom())};
            5, 6:    f = {1'b0, 8'($urandom_range(132, 140)), 23'h7FFFFF - 23'($urandom_range(0, 4096))};
            7:       f = sp[$urandom_range(0, 5)];
            8:       f = {1'b1, 8'($urandom_range(100, 140)), 23'($urandom())};
            default: f = {1'b0, 8'($urandom_range(124, 127)), 23'($urandom())};
        endcase
        return f;
    endfunction

    // Monitor: pops and compares on every output transfer, and checks that a
    // stalled output stays put.
    bit          holding = 1'b0;
    logic [7:0]  hr, hg, hb;
    always @(negedge CLK) begin
        exp_t e;
        #2;
        if (!CLEAR) begin
            holding = 1'b0;
        end else begin
            if (holding) begin
                chk("hold_valid", int'(ENABLE_OUT), 1);
                chk("hold_red", int'(Red_Out), int'(hr));
                chk("hold_green", int'(Green_Out), int'(hg));
                chk("hold_blue", int'(Blue_Out), int'(hb));
            end
            if (ENABLE_OUT && READY_OUT) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("red8", int'(Red_Out), e.r8);
                    chk("green8", int'(Green_Out), e.g8);
                    chk("blue8", int'(Blue_Out), e.b8);
                    chk("valid12", int'(ENABLE_OUT12), 1);
                    chk("red12", int'(Red_Out12), e.r12);
                    chk("green12", int'(Green_Out12), e.g12);
                    chk("blue12", int'(Blue_Out12), e.b12);
`ifdef FTI_SAT_FLAG_EN
                    chk("sat8", int'(SAT_FLAG), e.s8);
                    chk("sat12", int'(SAT_FLAG12), e.s12);
`endif
                    if (e.lat) chk("latency", cyc + 1 - e.acc, 2);
                end
            end
            holding = ENABLE_OUT && !READY_OUT;
            hr = Red_Out;
            hg = Green_Out;
            hb = Blue_Out;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] st [10];
        int          item, idx;
        bit          a;

        #3;
        chk("rst_valid", int'(ENABLE_OUT), 0);
        chk("rst_red", int'(Red_Out), 0);
        chk("rst_blue12", int'(Blue_Out12), 0);
        chk("rst_ready_in", int'(READY_IN), 1);

        @(negedge CLK);
        CLEAR = 1'b1;
        #1;
        chk("ready_after_release", int'(READY_IN), 1);

        // Directed corner values, unstalled so latency is exact.
        send(32'h437F0000, 32'h40200000, 32'h3F000000, 1'b1, 1'b1);
        idle(4, 1'b1);
        send(32'hBF800000, 32'h7FC00000, 32'h447A0000, 1'b1, 1'b1);
        send(32'h3EFFFFFF, 32'h00000001, 32'h7F800000, 1'b1, 1'b1);
        send(32'h457FF800, 32'h80000000, 32'hFF800000, 1'b1, 1'b1);
        send(32'h3F7FFFFF, 32'h3EFFFFFF, 32'h437F4000, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Back-to-back stream of 10 with a downstream stall on cycles 3..6.
        for (int i = 0; i < 10; i++) st[i] = {1'b0, 8'(128 + i), 23'($urandom())};
        item = 0;
        idx  = 0;
        while (item < 10 && idx < 100) begin
            drive(1'b1, st[item], st[(item + 3) % 10], st[(item + 7) % 10],
                  !(idx >= 3 && idx <= 6), 1'b0, a);
            if (idx == 5) chk("ready_in_stalled", int'(READY_IN), 0);
            if (a) item++;
            idx++;
        end
        chk("stream_sent", item, 10);
        idle(6, 1'b1);
        chk("stream_drained", q.size(), 0);

        // Reset with both stages full.
        drive(1'b1, 32'h42000000, 32'h42000000, 32'h42000000, 1'b0, 1'b0, a);
        drive(1'b1, 32'h42100000, 32'h42100000, 32'h42100000, 1'b0, 1'b0, a);
        @(negedge CLK);
        ENABLE_IN = 1'b0;
        #3;
        CLEAR = 1'b0;
        q.delete();
        #1;
        chk("clr_valid", int'(ENABLE_OUT), 0);
        chk("clr_red", int'(Red_Out), 0);
        chk("clr_green12", int'(Green_Out12), 0);
        chk("clr_ready_in", int'(READY_IN), 1);
        idle(2, 1'b1);
        @(negedge CLK);
        CLEAR = 1'b1;
        #1;
        chk("clr_release_ready", int'(READY_IN), 1);
        chk("clr_release_valid", int'(ENABLE_OUT), 0);
        idle(5, 1'b1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 4) != 0, rnd_float(), rnd_float(), rnd_float(),
                  $urandom_range(0, 3) != 0, 1'b0, a);
        end
        idle(8, 1'b1);
        chk("final_queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
